// File: rtl/wb_commit.sv
// Write-back commit stage: register file with same-cycle W->D bypass,
// a non-fall-through commit-trace FIFO and a saturating retire counter.
module wb_commit #(
    parameter int TRACE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemtoReg_W,
    input  logic        RegWrite_W,
    input  logic [31:0] ReadData_W,
    input  logic [4:0]  WriteReg_W,
    input  logic [31:0] PC_W,
    input  logic [31:0] RegData_W,
    input  logic [4:0]  RA1_D,
    input  logic [4:0]  RA2_D,
    output logic [31:0] RD1_D,
    output logic [31:0] RD2_D,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_reg,
    output logic [31:0] trace_data,
    output logic        trace_overflow,
    output logic [31:0] retire_count
);

    localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TRACE_DEPTH);

    logic [31:0] regs     [32];
    logic [31:0] pc_mem   [TRACE_DEPTH];
    logic [4:0]  reg_mem  [TRACE_DEPTH];
    logic [31:0] data_mem [TRACE_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      wd;
    logic             commit, full, pop, push;

    // A full FIFO can still accept a push when the head leaves in the same cycle.
    always_comb begin
        wd     = MemtoReg_W ? ReadData_W : RegData_W;
        commit = RegWrite_W && (WriteReg_W != 5'd0);
        full   = (count == FULL_CNT);
        pop    = (count != '0) && trace_ready;
        push   = commit && (!full || pop);
    end

    always_comb begin
        RD1_D = regs[RA1_D];
        if (RA1_D == 5'd0)
            RD1_D = '0;
        else if (commit && (WriteReg_W == RA1_D))
            RD1_D = wd;

        RD2_D = regs[RA2_D];
        if (RA2_D == 5'd0)
            RD2_D = '0;
        else if (commit && (WriteReg_W == RA2_D))
            RD2_D = wd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (commit) begin
            regs[WriteReg_W] <= wd;
        end
    end

    // Storage needs no reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= PC_W;
            reg_mem[wr_ptr]  <= WriteReg_W;
            data_mem[wr_ptr] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            trace_overflow <= 1'b0;
            retire_count   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (commit && full && !pop)
                trace_overflow <= 1'b1;
            if (commit && (retire_count != 32'hFFFF_FFFF))
                retire_count <= retire_count + 32'd1;
        end
    end

    always_comb begin
        trace_valid = (count != '0);
        trace_pc    = trace_valid ? pc_mem[rd_ptr]   : '0;
        trace_reg   = trace_valid ? reg_mem[rd_ptr]  : '0;
        trace_data  = trace_valid ? data_mem[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_wb_commit;

    localparam int TRACE_DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rg;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemtoReg_W, RegWrite_W, trace_ready;
    logic [31:0] ReadData_W, PC_W, RegData_W;
    logic [4:0]  WriteReg_W, RA1_D, RA2_D;
    logic [31:0] RD1_D, RD2_D, trace_pc, trace_data, retire_count;
    logic [4:0]  trace_reg;
    logic        trace_valid, trace_overflow;

    int n_compared = 0;
    int n_mismatched = 0;

    entry_t      m_q[$];
    logic [31:0] m_regs [32];
    logic        m_overflow;
    logic [31:0] m_retire;

    wb_commit #(.TRACE_DEPTH(TRACE_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .MemtoReg_W(MemtoReg_W), .RegWrite_W(RegWrite_W),
        .ReadData_W(ReadData_W), .WriteReg_W(WriteReg_W),
        .PC_W(PC_W), .RegData_W(RegData_W),
        .RA1_D(RA1_D), .RA2_D(RA2_D),
        .RD1_D(RD1_D), .RD2_D(RD2_D),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_reg(trace_reg), .trace_data(trace_data),
        .trace_overflow(trace_overflow), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and apply the architectural rules to the model.
    task automatic tick();
        logic [31:0] wd;
        wd = MemtoReg_W ? ReadData_W : RegData_W;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_q.delete();
            m_overflow = 1'b0;
            m_retire   = '0;
        end else begin
            if (trace_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (RegWrite_W && WriteReg_W != 0) begin
                m_regs[WriteReg_W] = wd;
                if (m_retire != 32'hFFFF_FFFF) m_retire = m_retire + 1;
                if (m_q.size() < TRACE_DEPTH)
                    m_q.push_back('{pc: PC_W, rg: WriteReg_W, data: wd});
                else
                    m_overflow = 1'b1;
            end
        end
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        RegWrite_W = 1'b0; MemtoReg_W = 1'b0; WriteReg_W = '0;
        ReadData_W = '0; RegData_W = '0; PC_W = '0;
    endtask

    task automatic drive_commit(input logic [4:0] wreg, input logic [31:0] pc,
                                input logic mtr, input logic [31:0] rdat,
                                input logic [31:0] ldat);
        RegWrite_W = 1'b1; MemtoReg_W = mtr; WriteReg_W = wreg;
        PC_W = pc; RegData_W = rdat; ReadData_W = ldat;
    endtask

    task automatic do_reset();
        reset = 1'b1; idle(); trace_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        idle(); trace_ready = 1'b1;
        repeat (TRACE_DEPTH + 1) tick();
        trace_ready = 1'b0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ra == 0) return '0;
        if (RegWrite_W && WriteReg_W == ra)
            return MemtoReg_W ? ReadData_W : RegData_W;
        return m_regs[ra];
    endfunction

    task automatic test_reset();
        reset = 1'b1; idle(); trace_ready = 1'b0; RA1_D = '0; RA2_D = '0;
        tick(); tick();
        reset = 1'b0;
        settle();
        n_compared++;
        if (trace_valid !== 1'b0 || trace_overflow !== 1'b0 || retire_count !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state: valid=%b ovf=%b retire=%0d want 0/0/0",
                     trace_valid, trace_overflow, retire_count);
        end
        n_compared++;
        if (trace_pc !== 32'd0 || trace_reg !== 5'd0 || trace_data !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_head: pc=%h reg=%0d data=%h want zeros",
                     trace_pc, trace_reg, trace_data);
        end
        for (int i = 0; i < 16; i++) begin
            RA1_D = 5'(2 * i); RA2_D = 5'(2 * i + 1);
            settle();
            n_compared++;
            if (RD1_D !== 32'd0 || RD2_D !== 32'd0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_rd[%0d]: got %h/%h want 0/0", i, RD1_D, RD2_D);
            end
            tick();
        end
    endtask

    task automatic test_basic_commit();
        drive_commit(5'd5, 32'h3000, 1'b0, 32'h1234, 32'h5555_AAAA);
        settle();
        n_compared++;
        if (trace_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL no_fall_through: got valid=%b want 0", trace_valid);
        end
        tick();
        idle(); RA1_D = 5'd5;
        settle();
        n_compared++;
        if (RD1_D !== 32'h1234) begin
            n_mismatched++;
            $display("[TB] FAIL basic_rd1: got %h want 00001234", RD1_D);
        end
        n_compared++;
        if (trace_valid !== 1'b1 || trace_pc !== 32'h3000 || trace_reg !== 5'd5 ||
            trace_data !== 32'h1234) begin
            n_mismatched++;
            $display("[TB] FAIL basic_head: got v=%b %h/%0d/%h want 1 3000/5/1234",
                     trace_valid, trace_pc, trace_reg, trace_data);
        end
        n_compared++;
        if (retire_count !== 32'd1) begin
            n_mismatched++;
            $display("[TB] FAIL basic_retire: got %0d want 1", retire_count);
        end
        drain();
    endtask

    task automatic test_bypass();
        drive_commit(5'd8, 32'h3100, 1'b1, 32'h0BAD_0BAD, 32'hDEAD_BEEF);
        RA1_D = 5'd3; RA2_D = 5'd8;
        settle();
        n_compared++;
        if (RD2_D !== 32'hDEAD_BEEF) begin
            n_mismatched++;
            $display("[TB] FAIL bypass_rd2: got %h want deadbeef", RD2_D);
        end
        n_compared++;
        if (RD1_D !== m_regs[3]) begin
            n_mismatched++;
            $display("[TB] FAIL bypass_rd1_other: got %h want %h", RD1_D, m_regs[3]);
        end
        tick();
        drain();
    endtask

    task automatic test_reg0();
        logic [31:0] saved;
        saved = m_retire;
        drive_commit(5'd0, 32'h3200, 1'b0, 32'hFFFF, 32'h0);
        RA1_D = 5'd0;
        settle();
        n_compared++;
        if (RD1_D !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reg0_bypass: got %h want 0", RD1_D);
        end
        tick();
        idle();
        settle();
        n_compared++;
        if (RD1_D !== 32'd0 || trace_valid !== 1'b0 || retire_count !== saved) begin
            n_mismatched++;
            $display("[TB] FAIL reg0_after: rd=%h valid=%b retire=%0d want 0/0/%0d",
                     RD1_D, trace_valid, retire_count, saved);
        end
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_commit(5'(i + 1), 32'h3000 + 32'(4 * i), 1'b0, 32'hA000 + 32'(i), 32'h0);
            if (i == 4) begin
                settle();
                n_compared++;
                if (trace_overflow !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL ovf_early: got %b want 0", trace_overflow);
                end
            end
            tick();
        end
        idle();
        settle();
        n_compared++;
        if (trace_overflow !== 1'b1 || retire_count !== 32'd5) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_state: ovf=%b retire=%0d want 1/5", trace_overflow, retire_count);
        end
        for (int r = 1; r <= 5; r++) begin
            RA1_D = 5'(r);
            settle();
            n_compared++;
            if (RD1_D !== 32'hA000 + 32'(r - 1)) begin
                n_mismatched++;
                $display("[TB] FAIL ovf_reg[%0d]: got %h want %h", r, RD1_D, 32'hA000 + 32'(r - 1));
            end
            tick();
        end
        trace_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            n_compared++;
            if (trace_valid !== 1'b1 || trace_pc !== 32'h3000 + 32'(4 * k)) begin
                n_mismatched++;
                $display("[TB] FAIL ovf_drain[%0d]: got v=%b pc=%h want 1 %h",
                         k, trace_valid, trace_pc, 32'h3000 + 32'(4 * k));
            end
            tick();
        end
        settle();
        n_compared++;
        if (trace_valid !== 1'b0 || trace_overflow !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_end: valid=%b ovf=%b want 0/1", trace_valid, trace_overflow);
        end
        tick();
        trace_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] want [4];
        want = '{32'h5004, 32'h5008, 32'h500C, 32'h4000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_commit(5'(20 + i), 32'h5000 + 32'(4 * i), 1'b0, 32'(i), 32'h0);
            tick();
        end
        drive_commit(5'd25, 32'h4000, 1'b0, 32'h4444, 32'h0);
        trace_ready = 1'b1;
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            settle();
            n_compared++;
            if (trace_valid !== 1'b1 || trace_pc !== want[k] || trace_overflow !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL full_pp[%0d]: got v=%b pc=%h ovf=%b want 1 %h 0",
                         k, trace_valid, trace_pc, trace_overflow, want[k]);
            end
            tick();
        end
        settle();
        n_compared++;
        if (trace_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL full_pp_empty: got valid=%b want 0", trace_valid);
        end
        tick();
        trace_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_commit(5'(10 + i), 32'h6000 + 32'(4 * i), 1'b0, 32'h77 + 32'(i), 32'h0);
            tick();
        end
        idle();
        settle();
        n_compared++;
        if (retire_count !== 32'd3 || trace_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL mid_pre: retire=%0d valid=%b want 3/1", retire_count, trace_valid);
        end
        tick();
        reset = 1'b1; trace_ready = 1'b1;
        drive_commit(5'd13, 32'h600C, 1'b0, 32'h9999, 32'h0);
        tick();
        reset = 1'b0; trace_ready = 1'b0; idle();
        RA1_D = 5'd13; RA2_D = 5'd10;
        settle();
        n_compared++;
        if (trace_valid !== 1'b0 || retire_count !== 32'd0 || RD1_D !== 32'd0 || RD2_D !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_post: valid=%b retire=%0d rd13=%h rd10=%h want 0/0/0/0",
                     trace_valid, retire_count, RD1_D, RD2_D);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] wpc, wrg, wdt;
        for (int c = 0; c < 400; c++) begin
            reset       = ($urandom_range(0, 59) == 0);
            RegWrite_W  = ($urandom_range(0, 3) != 0);
            MemtoReg_W  = 1'($urandom_range(0, 1));
            WriteReg_W  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            PC_W        = $urandom; RegData_W = $urandom; ReadData_W = $urandom;
            trace_ready = ($urandom_range(0, 2) == 0);
            RA1_D       = ($urandom_range(0, 3) == 0) ? WriteReg_W : 5'($urandom);
            RA2_D       = ($urandom_range(0, 3) == 0) ? WriteReg_W : 5'($urandom_range(0, 7));
            settle();
            wpc = (m_q.size() > 0) ? m_q[0].pc : '0;
            wrg = (m_q.size() > 0) ? 32'(m_q[0].rg) : '0;
            wdt = (m_q.size() > 0) ? m_q[0].data : '0;
            n_compared++;
            if (RD1_D !== exp_rd(RA1_D) || RD2_D !== exp_rd(RA2_D)) begin
                n_mismatched++;
                $display("[TB] FAIL rand_rd[%0d]: got %h/%h want %h/%h",
                         c, RD1_D, RD2_D, exp_rd(RA1_D), exp_rd(RA2_D));
            end
            n_compared++;
            if (trace_valid !== (m_q.size() > 0) || trace_pc !== wpc ||
                32'(trace_reg) !== wrg || trace_data !== wdt) begin
                n_mismatched++;
                $display("[TB] FAIL rand_head[%0d]: got v=%b %h/%0d/%h want v=%b %h/%0d/%h",
                         c, trace_valid, trace_pc, trace_reg, trace_data,
                         (m_q.size() > 0), wpc, wrg, wdt);
            end
            n_compared++;
            if (trace_overflow !== m_overflow || retire_count !== m_retire) begin
                n_mismatched++;
                $display("[TB] FAIL rand_status[%0d]: ovf=%b retire=%0d want %b/%0d",
                         c, trace_overflow, retire_count, m_overflow, m_retire);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; trace_ready = 1'b0; RA1_D = '0; RA2_D = '0;
        idle();
        #1;
        test_reset();
        test_basic_commit();
        test_bypass();
        test_reg0();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 The block SHALL use clock clk and reset reset; reset SHALL be synchronous and active-high.
REQ-002 Port list SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- MemtoReg_W, in, 1, select ReadData_W (1) or RegData_W (0) as write data.
- RegWrite_W, in, 1, W-stage register write enable.
- ReadData_W, in, 32, load data from the M/W pipeline register.
- WriteReg_W, in, 5, destination register number.
- PC_W, in, 32, PC of the W-stage instruction.
- RegData_W, in, 32, ALU/link result from the M/W pipeline register.
- RA1_D, in, 5, D-stage read address 1.
- RA2_D, in, 5, D-stage read address 2.
- RD1_D, out, 32, read data 1, combinational.
- RD2_D, out, 32, read data 2, combinational.
- trace_valid, out, 1, commit-trace FIFO head valid.
- trace_ready, in, 1, consumer accepts head.
- trace_pc, out, 32, head entry PC.
- trace_reg, out, 5, head entry destination register.
- trace_data, out, 32, head entry write data.
- trace_overflow, out, 1, sticky: a commit was dropped.
- retire_count, out, 32, number of committed writes.
REQ-003 Parameter TRACE_DEPTH SHALL default to 4 (power of two, minimum 2) and sets the trace FIFO depth.

Function
REQ-004 Write data WD SHALL equal ReadData_W when MemtoReg_W=1, otherwise RegData_W.
REQ-005 A commit SHALL occur in any cycle with RegWrite_W=1 and WriteReg_W!=0.
REQ-006 On a commit, register file entry [WriteReg_W] SHALL take WD at the clock edge; all other entries SHALL hold.
REQ-007 Register 0 SHALL always read 0; writes to register 0 SHALL be ignored and SHALL NOT count as commits.
REQ-008 RD1_D SHALL equal WD when a commit is present and WriteReg_W==RA1_D (same-cycle W->D bypass); otherwise it SHALL equal the stored entry [RA1_D]. RD2_D SHALL follow the same rule with RA2_D.
REQ-009 Each commit SHALL push {PC_W, WriteReg_W, WD} into the trace FIFO.
REQ-010 The FIFO SHALL pop its head at a clock edge when trace_valid=1 and trace_ready=1.
REQ-011 trace_valid SHALL be 1 exactly when FIFO occupancy is nonzero.
REQ-012 The trace_* data outputs SHALL present the head entry and SHALL be 0 when the FIFO is empty.
REQ-013 The FIFO SHALL NOT fall through: a push into an empty FIFO becomes visible on trace_* the next cycle.
REQ-014 If push and pop occur in the same cycle, occupancy SHALL be unchanged and the order SHALL be preserved. This holds when the FIFO is full.
REQ-015 If the FIFO is full and a push occurs without a pop, the entry SHALL be dropped, occupancy SHALL stay at TRACE_DEPTH, and trace_overflow SHALL set next cycle and remain set until reset.
REQ-016 The register file write SHALL occur regardless of FIFO state, including when a trace entry is dropped.
REQ-017 Read/write pointers SHALL wrap modulo TRACE_DEPTH; occupancy SHALL be tracked in a separate counter of width log2(TRACE_DEPTH)+1.
REQ-018 retire_count SHALL increment by 1 on each commit, including dropped-trace commits.
REQ-019 retire_count SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-020 While reset=1 at a clock edge, all 32 registers SHALL clear to 0.
REQ-021 While reset=1 at a clock edge, FIFO occupancy and both pointers SHALL clear to 0, giving trace_valid=0.
REQ-022 While reset=1 at a clock edge, trace_overflow SHALL clear to 0 and retire_count SHALL clear to 0.
REQ-023 Reset SHALL take priority over a simultaneous commit or pop; in-flight FIFO entries SHALL be discarded.
REQ-024 RD1_D and RD2_D SHALL read 0 for every address in the cycle after reset.

Verification
REQ-025 Basic commit: RegWrite=1, MemtoReg=0, WriteReg=5, RegData=0x1234, PC=0x3000 -> next cycle RD1_D(RA1=5)=0x1234; trace head {0x3000, 5, 0x1234}; retire_count=1.
REQ-026 Bypass: same cycle commit to reg 8 with MemtoReg=1, ReadData=0xDEADBEEF, RA2_D=8 -> RD2_D=0xDEADBEEF combinationally in that cycle.
REQ-027 Register 0: RegWrite=1, WriteReg=0, RegData=0xFFFF -> RD1_D(RA1=0)=0, no FIFO push, retire_count unchanged.
REQ-028 Overflow: trace_ready=0, 5 consecutive commits (PC 0x3000..0x3010) -> occupancy 4, trace_overflow=1, all 5 registers written, retire_count=5. Then trace_ready=1 -> heads 0x3000, 0x3004, 0x3008, 0x300C, then trace_valid=0.
REQ-029 Full push+pop: FIFO full, trace_ready=1 plus a commit at PC 0x4000 -> occupancy stays 4, no overflow, and 0x4000 emerges last.
REQ-030 Reset mid-operation: FIFO holding 3 entries with retire_count=3, assert reset for 1 cycle concurrent with a commit -> trace_valid=0, retire_count=0, register read of the committed address = 0.
